// File: rtl/mem_pkg.sv
// Shared defaults and pipeline-stage record for the multicycle memory.
package mem_pkg;

    localparam int unsigned DEF_ADDR_W      = 16;
    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_LATENCY     = 4;
    localparam int unsigned DEF_DEPTH_WORDS = 1024;

    // Control part of a pipeline stage; data travels in a parallel array sized by DATA_W.
    typedef struct packed {
        logic valid;
        logic err;
    } stage_ctrl_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module mem_array #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/multicycle_mem.sv
// Fixed-latency pipelined memory: one request per cycle, reads return LATENCY cycles later.
module multicycle_mem
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned LATENCY     = DEF_LATENCY,
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              err,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [IDX_W-1:0]  word_idx;
    logic [DATA_W-1:0] rdata;
    logic              mem_we;
    logic              rd_req;
    logic              misaligned;
    logic              unused_addr;

    stage_ctrl_t       stage_q [LATENCY];
    stage_ctrl_t       stage_d [LATENCY];
    logic [DATA_W-1:0] data_q  [LATENCY];
    logic [DATA_W-1:0] data_d  [LATENCY];

    // Bits above the word index alias onto the same storage.
    assign word_idx    = addr[IDX_W:1];
    assign unused_addr = ^addr[ADDR_W-1:IDX_W+1];
    assign misaligned  = addr[0];

    assign mem_we = rst_n & enable & wr & ~misaligned;
    assign rd_req = enable & ~wr;

    mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (data_in),
        .rdata (rdata)
    );

    always_comb begin
        stage_d[0].valid = rd_req;
        stage_d[0].err   = rd_req & misaligned;
        data_d[0]        = (rd_req && !misaligned) ? rdata : '0;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | stage_q[i].valid;
        end
    end

    assign data_valid = stage_q[LATENCY-1].valid;
    assign err        = stage_q[LATENCY-1].valid & stage_q[LATENCY-1].err;
    assign data_out   = stage_q[LATENCY-1].valid ? data_q[LATENCY-1] : '0;

endmodule

// File: tb/tb_multicycle_mem.sv
// Directed self-checking bench for multicycle_mem with default parameters.
module tb_multicycle_mem;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        data_valid;
    logic [15:0] data_out;
    logic        err;
    logic        busy;

    int n_tests;
    int n_fail;

    multicycle_mem dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_out   (data_out),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge.
    task automatic step(input logic en, input logic w, input logic [15:0] a,
                        input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        enable  = 1'b0;
        wr      = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic check_resp(input string tag, input logic [15:0] exp_data,
                              input logic exp_err);
        check({tag, ".valid"}, {31'b0, data_valid}, 32'd1);
        check({tag, ".data"}, {16'b0, data_out}, {16'b0, exp_data});
        check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    task automatic check_none(input string tag);
        check({tag, ".valid"}, {31'b0, data_valid}, 32'd0);
        check({tag, ".err"}, {31'b0, err}, 32'd0);
        check({tag, ".data"}, {16'b0, data_out}, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        data_in = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_none("reset");
        check("reset.busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;

        // Preload
        step(1'b1, 1'b1, 16'h0000, 16'h000A);
        step(1'b1, 1'b1, 16'h0002, 16'h000B);
        step(1'b1, 1'b1, 16'h0004, 16'h000C);
        step(1'b1, 1'b1, 16'h0020, 16'h7777);
        check_none("wr_no_resp");

        // Write then read back-to-back, exact latency
        step(1'b1, 1'b1, 16'h0010, 16'h1234);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        check("raw.busy", {31'b0, busy}, 32'd1);
        idle();
        idle();
        check_none("raw.early");
        idle();
        check_resp("raw", 16'h1234, 1'b0);
        idle();
        check_none("raw.after");
        check("raw.busy_end", {31'b0, busy}, 32'd0);

        // Three back-to-back reads return in order
        step(1'b1, 1'b0, 16'h0000, 16'h0);
        step(1'b1, 1'b0, 16'h0002, 16'h0);
        check("b2b.busy1", {31'b0, busy}, 32'd1);
        step(1'b1, 1'b0, 16'h0004, 16'h0);
        check_none("b2b.early");
        idle();
        check_resp("b2b0", 16'h000A, 1'b0);
        check("b2b.busy2", {31'b0, busy}, 32'd1);
        idle();
        check_resp("b2b1", 16'h000B, 1'b0);
        idle();
        check_resp("b2b2", 16'h000C, 1'b0);
        check("b2b.busy3", {31'b0, busy}, 32'd1);
        idle();
        check_none("b2b.after");
        check("b2b.busy_end", {31'b0, busy}, 32'd0);

        // Misaligned read and dropped misaligned write
        step(1'b1, 1'b0, 16'h0003, 16'h0);
        idle();
        idle();
        check_none("mis.early");
        idle();
        check_resp("mis", 16'h0000, 1'b1);
        step(1'b1, 1'b1, 16'h0003, 16'hDEAD);
        step(1'b1, 1'b0, 16'h0002, 16'h0);
        idle();
        idle();
        idle();
        check_resp("mis.keep", 16'h000B, 1'b0);

        // Reset discards in-flight reads and ignores requests during reset
        step(1'b1, 1'b0, 16'h0000, 16'h0);
        step(1'b1, 1'b0, 16'h0002, 16'h0);
        rst_n = 1'b0;
        step(1'b1, 1'b1, 16'h0004, 16'hFFFF);
        rst_n = 1'b1;
        check("rst.busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_none("rst.drop");
            idle();
        end
        step(1'b1, 1'b0, 16'h0004, 16'h0);
        idle();
        idle();
        idle();
        check_resp("rst.keep", 16'h000C, 1'b0);

        // Upper address bits alias onto word 0
        step(1'b1, 1'b1, 16'h0800, 16'hBEEF);
        step(1'b1, 1'b0, 16'h0000, 16'h0);
        idle();
        idle();
        idle();
        check_resp("alias", 16'hBEEF, 1'b0);

        // Write in the bubble between two reads of the same word
        step(1'b1, 1'b0, 16'h0020, 16'h0);
        step(1'b1, 1'b1, 16'h0020, 16'h5555);
        step(1'b1, 1'b0, 16'h0020, 16'h0);
        idle();
        check_resp("bub.old", 16'h7777, 1'b0);
        idle();
        check_none("bub.gap");
        check("bub.busy", {31'b0, busy}, 32'd1);
        idle();
        check_resp("bub.new", 16'h5555, 1'b0);
        idle();
        check("bub.busy_end", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
